// File: rtl/handshake_rr_control_merge.sv
// Round-robin merge of NUM_INPUTS valid/ready channels into one registered output slot.
// The slot carries the payload and the number of the channel that supplied it.
module handshake_rr_control_merge #(
  parameter int NUM_INPUTS  = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int INDEX_WIDTH = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] ins,
  input  logic [NUM_INPUTS-1:0]            ins_valid,
  output logic [NUM_INPUTS-1:0]            ins_ready,
  output logic [DATA_WIDTH-1:0]            outs,
  output logic [INDEX_WIDTH-1:0]           index,
  output logic                             outs_valid,
  input  logic                             outs_ready
);

  localparam int unsigned N_U = NUM_INPUTS;

  logic                   full_q, full_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic [INDEX_WIDTH-1:0] idx_q, idx_d;
  logic [INDEX_WIDTH-1:0] ptr_q, ptr_d;

  logic                   grant_found;
  logic [INDEX_WIDTH-1:0] grant_idx;
  logic [INDEX_WIDTH-1:0] grant_next;
  int unsigned            cand;
  logic                   can_accept;
  logic                   in_xfer;
  logic                   out_xfer;

  // First valid channel at or after ptr, wrapping past the last channel.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int unsigned k = 0; k < N_U; k++) begin
      cand = (32'(ptr_q) + k) % N_U;
      if (!grant_found && ins_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = INDEX_WIDTH'(cand);
      end
    end
  end

  assign grant_next = (grant_idx == INDEX_WIDTH'(N_U - 1)) ? '0 : grant_idx + 1'b1;
  assign can_accept = !full_q || outs_ready;
  // Gating with rst keeps ready low during reset even though the empty slot could accept.
  assign in_xfer    = grant_found && can_accept && rst;
  assign out_xfer   = full_q && outs_ready;

  always_comb begin
    ins_ready = '0;
    if (in_xfer) begin
      ins_ready[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    idx_d  = idx_q;
    ptr_d  = ptr_q;
    if (in_xfer) begin
      full_d = 1'b1;
      data_d = ins[32'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
      idx_d  = grant_idx;
      ptr_d  = grant_next;
    end else if (out_xfer) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full_q <= 1'b0;
      data_q <= '0;
      idx_q  <= '0;
      ptr_q  <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
      idx_q  <= idx_d;
      ptr_q  <= ptr_d;
    end
  end

  assign outs       = data_q;
  assign index      = idx_q;
  assign outs_valid = full_q;

endmodule

// File: tb/tb_handshake_rr_control_merge.sv
// Directed and randomized checks of the round-robin control merge (4 channels, 8-bit payload).
module tb_handshake_rr_control_merge;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk;
  logic           rst;
  logic [N*W-1:0] ins;
  logic [N-1:0]   ins_valid;
  logic [N-1:0]   ins_ready;
  logic [W-1:0]   outs;
  logic [1:0]     index;
  logic           outs_valid;
  logic           outs_ready;

  int n_tests;
  int n_fail;

  handshake_rr_control_merge #(
    .NUM_INPUTS (N),
    .DATA_WIDTH (W),
    .INDEX_WIDTH(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ins       (ins),
    .ins_valid (ins_valid),
    .ins_ready (ins_ready),
    .outs      (outs),
    .index     (index),
    .outs_valid(outs_valid),
    .outs_ready(outs_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves time at posedge+3 with the DUT out of reset and idle.
  task automatic do_reset();
    rst        = 1'b0;
    ins_valid  = '0;
    outs_ready = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
  endtask

  task automatic set_ch(input int ch, input logic [W-1:0] v);
    ins[ch*W +: W] = v;
  endtask

  // Bench-side round-robin model for the randomized run
  int           m_ptr;
  logic         m_full;
  logic [W-1:0] m_data;
  logic [1:0]   m_idx;
  logic [N-1:0] exp_ready;
  int           g;
  logic [N-1:0] last_cyc_valid;

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    ins        = '0;
    ins_valid  = 4'b1111;
    outs_ready = 1'b1;
    rst        = 1'b0;
    #1;
    check("rst_ready", 32'(ins_ready), 0);
    check("rst_valid", 32'(outs_valid), 0);
    step();
    check("rst_outs", 32'(outs), 0);
    check("rst_index", 32'(index), 0);
    check("rst_ready_clk", 32'(ins_ready), 0);

    // Single grant on channel 0, then ptr=1 shows as channel 1 winning over 0
    do_reset();
    ins_valid = 4'b0001; set_ch(0, 8'hFF); outs_ready = 1'b1;
    #1 check("s1_ready", 32'(ins_ready), 32'h1);
    check("s1_no_comb", 32'(outs_valid), 0);
    step();
    check("s1_outs", 32'(outs), 32'hFF);
    check("s1_index", 32'(index), 0);
    check("s1_valid", 32'(outs_valid), 1);
    ins_valid = 4'b0011;
    #1 check("s1_ptr1", 32'(ins_ready), 32'h2);

    // Rotation with all channels valid
    do_reset();
    for (int c = 0; c < N; c++) set_ch(c, 8'(8'h10 + c));
    ins_valid = 4'b1111; outs_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1 check($sformatf("s2_ready%0d", c), 32'(ins_ready), 32'(1 << (c % 4)));
      step();
      check($sformatf("s2_index%0d", c), 32'(index), 32'(c % 4));
      check($sformatf("s2_outs%0d", c), 32'(outs), 32'(8'h10 + (c % 4)));
    end

    // Backpressure holds the slot; release grants channel 2 in the same cycle
    do_reset();
    ins_valid = 4'b0001; set_ch(0, 8'hA0); outs_ready = 1'b0;
    step();
    ins_valid = 4'b0100; set_ch(2, 8'hC2);
    for (int c = 0; c < 3; c++) begin
      #1 check("s3_stall_ready", 32'(ins_ready), 0);
      step();
      check("s3_hold_outs", 32'(outs), 32'hA0);
      check("s3_hold_index", 32'(index), 0);
      check("s3_hold_valid", 32'(outs_valid), 1);
    end
    outs_ready = 1'b1;
    #1 check("s3_release_ready", 32'(ins_ready), 32'h4);
    step();
    check("s3_outs", 32'(outs), 32'hC2);
    check("s3_index", 32'(index), 2);
    ins_valid = '0;
    step();
    check("s3_drain_valid", 32'(outs_valid), 0);
    check("s3_drain_outs", 32'(outs), 32'hC2);
    check("s3_drain_index", 32'(index), 2);

    // Wrap-around from ptr=3, and ptr held while idle
    do_reset();
    ins_valid = 4'b0100; outs_ready = 1'b1;
    step();
    ins_valid = 4'b0011; set_ch(0, 8'h33);
    #1 check("s4_wrap_ready", 32'(ins_ready), 32'h1);
    step();
    check("s4_wrap_index", 32'(index), 0);
    ins_valid = '0;
    #1 check("s4_idle_ready", 32'(ins_ready), 0);
    step();
    ins_valid = 4'b1111;
    #1 check("s4_ptr_kept", 32'(ins_ready), 32'h2);

    // Asynchronous reset mid-cycle discards the held token
    do_reset();
    ins_valid = 4'b0010; set_ch(1, 8'h77); outs_ready = 1'b0;
    step();
    ins_valid = '0;
    check("s5_full", 32'(outs_valid), 1);
    #2 rst = 1'b0;
    #1;
    check("s5_async_valid", 32'(outs_valid), 0);
    check("s5_async_outs", 32'(outs), 0);
    check("s5_async_index", 32'(index), 0);
    step();
    #2 rst = 1'b1;
    ins_valid = 4'b1000; set_ch(3, 8'h5A); outs_ready = 1'b1;
    #1 check("s5_after_ready", 32'(ins_ready), 32'h8);
    step();
    check("s5_after_index", 32'(index), 3);
    check("s5_after_outs", 32'(outs), 32'h5A);

    // Randomized valid/ready against the bench model
    do_reset();
    m_ptr = 0; m_full = 1'b0; m_data = '0; m_idx = '0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      ins_valid  = 4'($urandom_range(0, 15));
      ins        = $urandom;
      outs_ready = 1'($urandom_range(0, 1));
      #1;
      exp_ready = '0;
      g = -1;
      for (int k = 0; k < N; k++) begin
        if (g < 0 && ins_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      end
      if (g >= 0 && (!m_full || outs_ready)) exp_ready[g] = 1'b1;
      check("rnd_ready", 32'(ins_ready), 32'(exp_ready));
      check("rnd_valid", 32'(outs_valid), 32'(m_full));
      if (m_full) begin
        check("rnd_outs", 32'(outs), 32'(m_data));
        check("rnd_index", 32'(index), 32'(m_idx));
      end
      if (exp_ready != '0) begin
        m_full = 1'b1;
        m_data = ins[g*W +: W];
        m_idx  = 2'(g);
        m_ptr  = (g + 1) % N;
      end else if (m_full && outs_ready) begin
        m_full = 1'b0;
      end
      last_cyc_valid = ins_valid;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
